packet_scheduler: RTL

PACKET_SCHEDULER -- requirements
Module: packet_scheduler

---
 rtl/lightboard_pkg.sv | 27 ++
 rtl/packet_scheduler_if.sv | 30 +++
 rtl/cycle_timer.sv | 29 ++
 rtl/packet_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lightboard_pkg.sv
// Shared types and default constants for the lightboard packet scheduler.
package lightboard_pkg;

  localparam int ADDR_W             = 24;
  localparam int DEF_PIXELS_PER_PKT = 320;
  localparam int DEF_FRAME_PIXELS   = 76800;
  localparam int DEF_IPG_CYCLES     = 48;
  localparam int DEF_AUDIO_EVERY    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } sched_state_t;

  typedef enum logic {
    KIND_VIDEO = 1'b0,
    KIND_AUDIO = 1'b1
  } pkt_kind_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/packet_scheduler_if.sv
// Control/handshake bundle between the scheduler, frame/audio sources and serializer.
interface packet_scheduler_if;
  import lightboard_pkg::*;

  logic              enable;
  logic              frame_ready;
  logic              audio_ready;
  logic              phy_ready;
  logic              ser_done;
  logic              ser_start;
  logic              ser_kind;
  logic [ADDR_W-1:0] ser_base_addr;
  logic              ser_stall;
  logic              frame_done;
  logic              err_timeout;
  logic              err_overrun;

  modport master (
    input  enable, frame_ready, audio_ready, phy_ready, ser_done,
    output ser_start, ser_kind, ser_base_addr, ser_stall,
           frame_done, err_timeout, err_overrun
  );

  modport slave (
    output enable, frame_ready, audio_ready, phy_ready, ser_done,
    input  ser_start, ser_kind, ser_base_addr, ser_stall,
           frame_done, err_timeout, err_overrun
  );

endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter; expire flags terminal count (zero). Shared by the
// packet watchdog and the inter-packet gap.
module cycle_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_count,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  // Load has priority; counting stops at zero so expire stays asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/packet_scheduler.sv
// Packet scheduler: interleaves video packets of a frame with audio packets,
// enforces the inter-packet gap and guards each packet with a watchdog.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | nothing in flight; waits for enable, phy and pending work
// ISSUE     | one cycle; picks audio or video and pulses ser_start
// WAIT_DONE | packet on the wire; ends on done, phy drop or watchdog
// GAP       | fixed idle gap before the next packet may be issued
module packet_scheduler
  import lightboard_pkg::*;
#(
  parameter int PIXELS_PER_PKT = DEF_PIXELS_PER_PKT,
  parameter int FRAME_PIXELS   = DEF_FRAME_PIXELS,
  parameter int IPG_CYCLES     = DEF_IPG_CYCLES,
  parameter int AUDIO_EVERY    = DEF_AUDIO_EVERY,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                 clk,
  input logic                 rst_n,
  packet_scheduler_if.master  bus
);

  localparam int TMR_W = $clog2(max_int(TIMEOUT_CYCLES, IPG_CYCLES));
  localparam int CNT_W = $clog2(AUDIO_EVERY + 1);
  localparam logic [ADDR_W-1:0] PKT_STEP   = ADDR_W'(PIXELS_PER_PKT);
  localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0]  AUDIO_SAT  = CNT_W'(AUDIO_EVERY);
  localparam logic [TMR_W-1:0]  TMO_LOAD   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  GAP_LOAD   = TMR_W'(IPG_CYCLES - 1);

  sched_state_t      r_state;
  pkt_kind_t         r_kind;
  logic              r_ser_start;
  logic              r_ser_stall;
  logic              r_err_timeout;
  logic              r_frame_done;
  logic              r_err_overrun;
  logic              r_frame_active;
  logic              r_frame_pending;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_vid_since;

  logic              w_can_issue;
  logic              w_pick_audio;
  logic              w_wait_exit;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_tmr_count;
  logic              w_tmr_expire;
  logic              w_vid_done;
  logic              w_aud_done;
  logic [ADDR_W-1:0] w_base_sum;
  logic              w_frame_end;
  logic              w_active_nxt;
  logic              w_pending_nxt;
  logic [ADDR_W-1:0] w_base_nxt;
  logic              w_overrun_nxt;

  assign w_can_issue  = bus.enable && bus.phy_ready && (r_frame_active || bus.audio_ready);
  assign w_pick_audio = bus.audio_ready && ((r_vid_since >= AUDIO_SAT) || !r_frame_active);

  // Any exit from WAIT_DONE (done, phy drop, watchdog) reloads the timer for the gap.
  assign w_wait_exit  = (r_state == ST_WAIT_DONE) &&
                        (bus.ser_done || !bus.phy_ready || w_tmr_expire);
  assign w_tmr_load   = (r_state == ST_ISSUE) || w_wait_exit;
  assign w_tmr_val    = (r_state == ST_ISSUE) ? TMO_LOAD : GAP_LOAD;
  assign w_tmr_count  = (r_state == ST_WAIT_DONE) || (r_state == ST_GAP);

  cycle_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_count    (w_tmr_count),
    .o_expire   (w_tmr_expire)
  );

  // Only a done seen while a packet is in flight counts; strays are ignored.
  assign w_vid_done  = (r_state == ST_WAIT_DONE) && bus.ser_done && (r_kind == KIND_VIDEO);
  assign w_aud_done  = (r_state == ST_WAIT_DONE) && bus.ser_done && (r_kind == KIND_AUDIO);
  assign w_base_sum  = r_base + PKT_STEP;
  assign w_frame_end = (w_base_sum == FRAME_END);

  // Frame bookkeeping: apply packet completion first, then a same-cycle frame_ready.
  always_comb begin
    w_active_nxt  = r_frame_active;
    w_pending_nxt = r_frame_pending;
    w_base_nxt    = r_base;
    w_overrun_nxt = 1'b0;
    if (w_vid_done) begin
      if (w_frame_end) begin
        w_base_nxt    = '0;
        w_active_nxt  = r_frame_pending;
        w_pending_nxt = 1'b0;
      end else begin
        w_base_nxt = w_base_sum;
      end
    end
    if (bus.frame_ready) begin
      if (!w_active_nxt) begin
        w_active_nxt = 1'b1;
        w_base_nxt   = '0;
      end else if (!w_pending_nxt) begin
        w_pending_nxt = 1'b1;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end
  end

  // Frame/address registers, audio fairness counter and their status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_active  <= 1'b0;
      r_frame_pending <= 1'b0;
      r_base          <= '0;
      r_frame_done    <= 1'b0;
      r_err_overrun   <= 1'b0;
      r_vid_since     <= '0;
    end else begin
      r_frame_active  <= w_active_nxt;
      r_frame_pending <= w_pending_nxt;
      r_base          <= w_base_nxt;
      r_frame_done    <= w_vid_done && w_frame_end;
      r_err_overrun   <= w_overrun_nxt;
      if (w_aud_done) begin
        r_vid_since <= '0;
      end else if (w_vid_done && (r_vid_since != AUDIO_SAT)) begin
        r_vid_since <= r_vid_since + 1'b1;
      end
    end
  end

  // Scheduler FSM with registered serializer controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_kind        <= KIND_VIDEO;
      r_ser_start   <= 1'b0;
      r_ser_stall   <= 1'b1;
      r_err_timeout <= 1'b0;
    end else begin
      r_ser_start   <= 1'b0;
      r_err_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_can_issue) r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (w_pick_audio || r_frame_active) begin
            r_kind      <= w_pick_audio ? KIND_AUDIO : KIND_VIDEO;
            r_state     <= ST_WAIT_DONE;
            r_ser_start <= 1'b1;
            r_ser_stall <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT_DONE: begin
          // Aborts leave the address untouched so the packet is resent.
          if (bus.ser_done || !bus.phy_ready) begin
            r_state     <= ST_GAP;
            r_ser_stall <= 1'b1;
          end else if (w_tmr_expire) begin
            r_state       <= ST_GAP;
            r_ser_stall   <= 1'b1;
            r_err_timeout <= 1'b1;
          end
        end
        ST_GAP: begin
          if (w_tmr_expire) r_state <= w_can_issue ? ST_ISSUE : ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_ser_stall <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ser_start     = r_ser_start;
  assign bus.ser_kind      = r_kind;
  assign bus.ser_base_addr = r_base;
  assign bus.ser_stall     = r_ser_stall;
  assign bus.frame_done    = r_frame_done;
  assign bus.err_timeout   = r_err_timeout;
  assign bus.err_overrun   = r_err_overrun;

endmodule
